// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the seven-segment digit scanner.
//   SEG7_NUM_DIGITS / SEG7_REFRESH_DIV / SEG7_BLANK_CYCLES : default parameters
//   SEG7_AN_OFF : all anodes off (active-low), sliced to the digit count in use
//   digit_t     : one hex nibble as presented to segment_7_binary.data_in
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG7_NUM_DIGITS   = 4;
    localparam int SEG7_REFRESH_DIV  = 100000;
    localparam int SEG7_BLANK_CYCLES = 1000;

    // Widest supported display; narrower builds take the low bits.
    localparam int SEG7_MAX_DIGITS   = 8;
    localparam logic [SEG7_MAX_DIGITS-1:0] SEG7_AN_OFF = '1;

    typedef logic [3:0] digit_t;

endpackage

// File: rtl/seg7_refresh_divider.sv
// -----------------------------------------------------------------------------
// seg7_refresh_divider
// Free-running slot counter for the digit scanner.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   slot_tick_o  : high during the last cycle of each REFRESH_DIV-cycle slot
//   in_blank_o   : high while the counter is inside the leading blank window
// -----------------------------------------------------------------------------
module seg7_refresh_divider #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic clk,
    input  logic rst,
    output logic slot_tick_o,
    output logic in_blank_o
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    always_comb begin
        slot_tick_o = (div_cnt_q == CNT_LAST);
        div_cnt_d   = slot_tick_o ? '0 : div_cnt_q + 1'b1;
    end

    // A zero-length blank window would make the compare constant, so it is
    // elaborated away instead.
    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign in_blank_o = (div_cnt_q < BLANK_END);
        end else begin : g_no_blank
            assign in_blank_o = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/seg7_digit_scanner.sv
// -----------------------------------------------------------------------------
// seg7_digit_scanner
// Time-multiplexes a NUM_DIGITS-digit hex value onto one seven-segment bus.
// A load strobe copies value_in into a shadow register; the scan only ever
// reads the shadow. Each slot starts with BLANK_CYCLES of all-anodes-off to
// suppress ghosting while the segment lines settle on the next digit.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   value_in  : digits to show, digit k at [4k+3:4k], digit 0 rightmost
//   load      : latch value_in into the shadow register on this edge
//   digit_out : nibble of the digit being shown (to segment_7_binary.data_in)
//   an        : active-low anode enables, one-hot-low when lit
//   digit_idx : index of the current slot
//   slot_tick : high on the last cycle of each slot
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to keep leading zero digits
// (all but digit 0) dark.
// -----------------------------------------------------------------------------
module seg7_digit_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = SEG7_NUM_DIGITS,
    parameter int REFRESH_DIV  = SEG7_REFRESH_DIV,
    parameter int BLANK_CYCLES = SEG7_BLANK_CYCLES,
    localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    output digit_t                  digit_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    slot_tick
);

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = SEG7_AN_OFF[NUM_DIGITS-1:0];

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    digit_t                  digit_q, digit_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [NUM_DIGITS-1:0]   an_lit;
    logic                    in_blank;
    logic                    lz_blank;

    seg7_refresh_divider #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .slot_tick_o (slot_tick),
        .in_blank_o  (in_blank)
    );

    always_comb begin
        shadow_d    = load ? value_in : shadow_q;
        digit_idx_d = digit_idx_q;
        if (slot_tick) begin
            digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
        end
    end

    // Outputs are decoded from the registered state, so digit, anode and
    // shadow always come from the same cycle: a load landing on a slot_tick
    // edge shows up together with the new slot, never half-old/half-new.
    always_comb begin
        digit_d = '0;
        an_lit  = AN_OFF;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx_q == IDX_W'(k)) begin
                digit_d   = shadow_q[4*k +: 4];
                an_lit[k] = 1'b0;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Walk down from the most significant digit; a digit is a leading zero
    // while it and everything above it is zero. Digit 0 is never blanked.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = 1'b0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_above = zero_above && (shadow_q[4*k +: 4] == 4'h0);
            if ((digit_idx_q == IDX_W'(k)) && zero_above) begin
                lz_blank = 1'b1;
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign an_d = (in_blank || lz_blank) ? AN_OFF : an_lit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q    <= '0;
            digit_idx_q <= '0;
            digit_q     <= '0;
            an_q        <= AN_OFF;
        end else begin
            shadow_q    <= shadow_d;
            digit_idx_q <= digit_idx_d;
            digit_q     <= digit_d;
            an_q        <= an_d;
        end
    end

    assign digit_out = digit_q;
    assign an        = an_q;
    assign digit_idx = digit_idx_q;

endmodule
